// File: rtl/dmem_pkg.sv
// dmem_pkg: access size and FSM state types, byte-lane enable and load-extension helpers.
// Feature macro DMEM_MISALIGN_CHK_EN is consumed by dmem_ctrl.
package dmem_pkg;

    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    // Low address bits a size cannot use are ignored, which gives the masked misalignment behaviour
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        return size == SZ_BYTE ? 4'b0001 << lane :
               size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) :
               size == SZ_WORD ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        return size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
               size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W RAM with byte-enable write and registered read.
// Word i powers up holding i; reset never touches the contents.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic [3:0]        be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    typedef logic [DATA_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = DATA_W'(i);
        return m;
    endfunction

    mem_t mem = init_mem();

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data memory controller with valid/ready request, wait states and a one-cycle response.
// Define DMEM_MISALIGN_CHK_EN to flag misaligned half/word accesses as errors instead of masking them.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);

    state_e              state, state_nxt;
    logic [3:0]          cnt;
    logic                l_write, l_uns;
    logic [1:0]          l_size;
    logic [ADDR_W-1:0]   l_addr;
    logic [DATA_W-1:0]   l_wdata;
    logic                c_write, c_err, l_err, accept, access;
    logic [1:0]          c_size;
    logic [ADDR_W-1:0]   c_addr;
    logic [DATA_W-1:0]   c_wdata, rd_word;

    function automatic logic illegal(input logic [1:0] size, input logic [ADDR_W-1:0] addr);
        return size == 2'b11 || |(addr >> (AW + 2))
`ifdef DMEM_MISALIGN_CHK_EN
            || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00)
`endif
            ;
    endfunction

    // With no wait states the access happens on the accept edge, so it must see the live request
    assign accept  = req_valid && state == S_IDLE;
    assign c_write = state == S_IDLE ? req_write : l_write;
    assign c_size  = state == S_IDLE ? req_size  : l_size;
    assign c_addr  = state == S_IDLE ? req_addr  : l_addr;
    assign c_wdata = state == S_IDLE ? req_wdata : l_wdata;
    assign c_err   = illegal(c_size, c_addr);
    assign access  = state == S_IDLE ? accept && WAIT_CYCLES == 0 : state == S_WAIT && cnt == 4'd0;

    dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .addr  (c_addr[AW+1:2]),
        .be    (access && c_write && !c_err ? lane_mask(c_size, c_addr[1:0]) : 4'b0000),
        .wdata (c_size == SZ_BYTE ? {4{c_wdata[7:0]}} : c_size == SZ_HALF ? {2{c_wdata[15:0]}} : c_wdata),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            l_write <= 1'b0;
            l_uns   <= 1'b0;
            l_size  <= '0;
            l_addr  <= '0;
            l_wdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                l_write <= req_write;
                l_uns   <= req_unsigned;
                l_size  <= req_size;
                l_addr  <= req_addr;
                l_wdata <= req_wdata;
                cnt     <= 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state == S_IDLE ? (accept ? (WAIT_CYCLES == 0 ? S_RESP : S_WAIT) : S_IDLE) :
                    state == S_WAIT ? (cnt == 4'd0 ? S_RESP : S_WAIT) : S_IDLE;
        req_ready = state == S_IDLE;
        busy      = state != S_IDLE;
        rsp_valid = state == S_RESP;
        l_err     = illegal(l_size, l_addr);
        rsp_err   = rsp_valid && l_err;
        rsp_rdata = rsp_valid && !l_write && !l_err ? load_extend(rd_word, l_size, l_addr[1:0], l_uns) : '0;
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: two controllers (0 and 3 wait states) checked each cycle against a byte-addressed memory model.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  v, rdy, rv, re, bz;
    logic        w, u;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic [31:0] rd [2];

    int checks = 0, errors = 0, cyc = 0;
    int pend [2] = '{0, 0};
    int acc  [2] = '{0, 0};
    logic [31:0] xd [2];
    logic        xe [2];
    localparam int WC [2] = '{0, 3};
    logic [7:0]  mb [2][1024];
    logic        eb, ev;

    dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[0]), .req_ready(rdy[0]), .req_write(w),
        .req_size(sz), .req_unsigned(u), .req_addr(a), .req_wdata(wd),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]), .busy(bz[0]));

    dmem_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v[1]), .req_ready(rdy[1]), .req_write(w),
        .req_size(sz), .req_unsigned(u), .req_addr(a), .req_wdata(wd),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]), .busy(bz[1]));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", n, i, act, exp);
        end
    endtask

    // Memory seen as a flat byte array; alignment comes from rounding the address down to the access size
    function automatic void model(input int i, input logic tw, input logic [1:0] ts, input logic tu,
                                  input logic [31:0] ta, input logic [31:0] twd,
                                  output logic [31:0] d, output logic e);
        int n, base;
        logic [31:0] val;
        n = ts == 2'd0 ? 1 : ts == 2'd1 ? 2 : 4;
        base = int'(ta) - int'(ta % n);
        e = ts == 2'd3 || ta >= 32'd1024;
`ifdef DMEM_MISALIGN_CHK_EN
        if (ta % n != 0) e = 1'b1;
`endif
        d = 0;
        if (!e) begin
            if (tw) begin
                for (int k = 0; k < n; k++) mb[i][base + k] = twd[8*k +: 8];
            end else begin
                val = 0;
                for (int k = 0; k < n; k++) val |= 32'(mb[i][base + k]) << (8 * k);
                if (!tu && n < 4 && val[8*n-1]) val |= 32'hFFFFFFFF << (8 * n);
                d = val;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                eb = pend[i] != 0 && cyc >= acc[i] && cyc <= acc[i] + WC[i];
                ev = eb && cyc == acc[i] + WC[i];
                chk("busy", i, bz[i], eb);
                chk("req_ready", i, rdy[i], !eb);
                chk("rsp_valid", i, rv[i], ev);
                if (ev) begin
                    chk("rsp_rdata", i, rd[i], xd[i]);
                    chk("rsp_err", i, re[i], xe[i]);
                end
            end
        end
    end

    task automatic txn(input logic [1:0] m, input logic tw, input logic [1:0] ts, input logic tu,
                       input logic [31:0] ta, input logic [31:0] twd, input logic [31:0] ed, input logic ee);
        logic [31:0] d;
        logic e;
        @(negedge clk);
        w = tw; sz = ts; u = tu; a = ta; wd = twd; v = m;
        @(posedge clk);
        #1 v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (m[i]) begin
                model(i, tw, ts, tu, ta, twd, d, e);
                pend[i] = 1; acc[i] = cyc; xd[i] = d; xe[i] = e;
            end
        end
        chk("model_rdata", 0, d, ed);
        chk("model_err", 0, 32'(e), 32'(ee));
        a = 32'hFFFFFFFF; wd = ~twd; w = ~tw; sz = 2'b11;
        repeat (4) @(negedge clk);
    endtask

    task automatic rstchk();
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", i, rdy[i], 1);
            chk("rst_rsp_valid", i, rv[i], 0);
            chk("rst_rsp_rdata", i, rd[i], 0);
            chk("rst_rsp_err", i, re[i], 0);
            chk("rst_busy", i, bz[i], 0);
        end
    endtask

    initial begin
        v = 2'b00; w = 1'b0; sz = 2'b00; u = 1'b0; a = '0; wd = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 1024; j++) mb[i][j] = j % 4 == 0 ? 8'(j / 4) : 8'h00;
        repeat (2) @(posedge clk);
        #1 rstchk();
        @(negedge clk) rst_n = 1'b1;
        txn(2'b11, 1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0);
        txn(2'b11, 0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
        txn(2'b11, 1, 2'd0, 0, 32'h21,  32'h12345680, 32'h0,        0);
        txn(2'b11, 0, 2'd2, 0, 32'h20,  32'h0,        32'h00008008, 0);
        txn(2'b11, 0, 2'd0, 0, 32'h21,  32'h0,        32'hFFFFFF80, 0);
        txn(2'b11, 0, 2'd0, 1, 32'h21,  32'h0,        32'h00000080, 0);
        txn(2'b11, 0, 2'd2, 0, 32'h0C,  32'h0,        32'h00000003, 0);
        txn(2'b11, 1, 2'd1, 0, 32'h42,  32'hFFFF8001, 32'h0,        0);
        txn(2'b11, 0, 2'd1, 0, 32'h42,  32'h0,        32'hFFFF8001, 0);
        txn(2'b11, 0, 2'd2, 0, 32'h40,  32'h0,        32'h80010010, 0);
        txn(2'b11, 1, 2'd2, 0, 32'h400, 32'h12345678, 32'h0,        1);
        txn(2'b11, 0, 2'd2, 0, 32'h400, 32'h0,        32'h0,        1);
        txn(2'b11, 0, 2'd3, 0, 32'h10,  32'h0,        32'h0,        1);
        txn(2'b11, 1, 2'd3, 0, 32'h10,  32'h0,        32'h0,        1);
        txn(2'b11, 0, 2'd2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
`ifdef DMEM_MISALIGN_CHK_EN
        txn(2'b11, 0, 2'd2, 0, 32'h13,  32'h0,        32'h0,        1);
        txn(2'b11, 0, 2'd1, 1, 32'h43,  32'h0,        32'h0,        1);
`else
        txn(2'b11, 0, 2'd2, 0, 32'h13,  32'h0,        32'hDEADBEEF, 0);
        txn(2'b11, 0, 2'd1, 1, 32'h43,  32'h0,        32'h00008001, 0);
`endif
        txn(2'b11, 1, 2'd0, 0, 32'h3FF, 32'h0000005A, 32'h0,        0);
        txn(2'b11, 0, 2'd2, 0, 32'h3FC, 32'h0,        32'h5A0000FF, 0);
        // Store into the 3-wait-state block, abandoned by reset while it waits
        @(negedge clk);
        w = 1'b1; sz = 2'd2; u = 1'b0; a = 32'h08; wd = 32'hAAAA5555; v = 2'b10;
        @(posedge clk);
        #1 v = 2'b00; pend[1] = 1; acc[1] = cyc; xd[1] = '0; xe[1] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0; pend[1] = 0;
        #1 rstchk();
        @(negedge clk);
        #1 rst_n = 1'b1;
        txn(2'b11, 0, 2'd2, 0, 32'h08,  32'h0,        32'h00000002, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
